// File: rtl/dmem_pkg.sv
// Shared types and constants for the stalling data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and dmem_responder.
// Err exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_responder_if;
  logic        MemEnable;
  logic        MemWr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Stall;
  logic        Done;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        Err;

  modport master (output MemEnable, MemWr, Addr, DataIn,
                  input  DataOut, Stall, Done, Err);
  modport slave  (input  MemEnable, MemWr, Addr, DataIn,
                  output DataOut, Stall, Done, Err);
`else
  modport master (output MemEnable, MemWr, Addr, DataIn,
                  input  DataOut, Stall, Done);
  modport slave  (input  MemEnable, MemWr, Addr, DataIn,
                  output DataOut, Stall, Done);
`endif
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous 16-bit RAM; read data is registered on the access
// edge and holds between reads. No reset on storage or read data.
module dmem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, stalls for LATENCY
// cycles, then pulses Done. Optional misalignment check: DMEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for MemEnable|MemWr; request accepted here
// BUSY  | latency countdown; access executes on the edge leaving BUSY
// DONE  | one-cycle completion pulse, requests ignored
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_AW  = 8,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [MEM_AW-1:0]  cap_addr;
  logic [15:0]        cap_data;
  logic               cap_wr;
  logic               req, misaligned, exec, stall;
  logic               mem_wr;
  logic [MEM_AW-1:0]  mem_addr;
  logic [15:0]        mem_wdata, rdata;
  logic               dout_clr;
  logic               unused_addr_bits;

  assign req = bus.MemEnable | bus.MemWr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic cap_mis;
  assign misaligned = bus.Addr[0];
  assign bus.Err    = (state == DONE) && cap_mis;
`else
  assign misaligned = 1'b0;
`endif

  assign unused_addr_bits = ^{bus.Addr[15:MEM_AW+1], bus.Addr[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dout_clr <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (exec && !mem_wr) dout_clr <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    exec     = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (misaligned) begin
            state_nx = DONE;
          end else if (LOAD == '0) begin
            // single-cycle latency: execute on the accept edge itself
            exec     = 1'b1;
            state_nx = DONE;
          end else begin
            cnt_nx   = LOAD;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        stall  = 1'b1;
        cnt_nx = cnt - 1'b1;
        if (cnt_nx == '0) begin
          exec     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Captured request fields; both request bits high counts as a write.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      cap_addr <= bus.Addr[MEM_AW:1];
      cap_data <= bus.DataIn;
      cap_wr   <= bus.MemWr;
`ifdef DMEM_ALIGN_CHECK_EN
      cap_mis  <= bus.Addr[0];
`endif
    end
  end

  assign mem_addr  = (state == IDLE) ? bus.Addr[MEM_AW:1] : cap_addr;
  assign mem_wdata = (state == IDLE) ? bus.DataIn         : cap_data;
  assign mem_wr    = (state == IDLE) ? bus.MemWr          : cap_wr;

  dmem_array #(.AW(MEM_AW)) u_array (
    .clk   (clk),
    .en    (exec && !rst),
    .we    (mem_wr),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  assign bus.DataOut = dout_clr ? 16'h0000 : rdata;
  assign bus.Stall   = stall;
  assign bus.Done    = (state == DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: accesses push expected DataOut/Err,
// a negedge monitor pops and compares on every Done pulse.
module tb_dmem_responder;

  localparam int LAT = 4;

  typedef struct {
    logic [15:0] dout;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  dmem_responder_if bus();

  dmem_responder #(.MEM_AW(8), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.Done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got Done with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk16("done_dataout", bus.DataOut, e.dout);
`ifdef DMEM_ALIGN_CHECK_EN
        chk1("done_err", bus.Err, e.err);
`endif
      end
    end
  end

  // Cycle 0 is the accept cycle; the request is dropped after it and Addr/DataIn
  // are scrambled so only captured values can produce the expected result.
  task automatic access(input logic me, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_dout,
                        input logic exp_err);
    int n;
    bus.MemEnable = me;
    bus.MemWr     = wr;
    bus.Addr      = a;
    bus.DataIn    = d;
    sb.push_back('{exp_dout, exp_err});
    n = exp_err ? 1 : LAT;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      chk1("stall_timing", bus.Stall, c < n);
      chk1("done_timing", bus.Done, c == n);
      @(posedge clk); #1;
      if (c == 0) begin
        bus.MemEnable = 1'b0;
        bus.MemWr     = 1'b0;
        bus.Addr      = a ^ 16'h0070;
        bus.DataIn    = ~d;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.MemEnable = 1'b0;
    bus.MemWr     = 1'b0;
    bus.Addr      = 16'h0000;
    bus.DataIn    = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_stall", bus.Stall, 1'b0);
    chk1("reset_done", bus.Done, 1'b0);
    chk16("reset_dataout", bus.DataOut, 16'h0000);
`ifdef DMEM_ALIGN_CHECK_EN
    chk1("reset_err", bus.Err, 1'b0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk16("dataout_hold", bus.DataOut, 16'hBEEF);

    // both request bits high -> write, DataOut untouched
    access(1'b1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);

    // scrambled inputs during BUSY point at 0x0040 with data 0xAAAA
    access(1'b0, 1'b1, 16'h0040, 16'h0404, 16'h1234, 1'b0);
    access(1'b0, 1'b1, 16'h0030, 16'h5555, 16'h1234, 1'b0);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0404, 1'b0);
    access(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b0);

    // reset in the second BUSY cycle of a write
    bus.MemWr  = 1'b1;
    bus.Addr   = 16'h0010;
    bus.DataIn = 16'hAAAA;
    @(posedge clk); #1;
    bus.MemWr = 1'b0;
    @(posedge clk); #1;
    chk1("busy2_stall", bus.Stall, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("rst_mid_stall", bus.Stall, 1'b0);
    chk1("rst_mid_done", bus.Done, 1'b0);
    chk16("rst_mid_dataout", bus.DataOut, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

    // address aliasing above MEM_AW
    access(1'b0, 1'b1, 16'h0202, 16'h7777, 16'hBEEF, 1'b0);
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h7777, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    access(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h7777, 1'b1);
    // misaligned write must not touch 0x0010
    access(1'b0, 1'b1, 16'h0011, 16'hDEAD, 16'h7777, 1'b1);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
`else
    access(1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1 chk16("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
